// File: rtl/button_counter_pkg.sv
// Shared types and constants for the push-button event counter.
// Build option AUTO_REPEAT_EN adds hold-to-repeat events.
package button_counter_pkg;

  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } db_state_t;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                               input int unsigned ms);
    return (clk_freq / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One active-low button: 2-FF synchronizer, debounce FSM, one-cycle event pulse.
// With AUTO_REPEAT_EN defined, a held button also emits periodic repeat pulses.
module button_debounce
  import button_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 25_000_000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic event_pulse
);

  localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int TIMER_W = $clog2(DB_CYCLES + 1);
  localparam logic [TIMER_W-1:0] DB_LAST = TIMER_W'(DB_CYCLES - 1);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_DELAY = ms_to_cycles(CLK_FREQ, REPEAT_DELAY_MS);
  localparam int unsigned REP_RATE  = ms_to_cycles(CLK_FREQ, REPEAT_RATE_MS);
  localparam int unsigned REP_MAX   = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int REP_W = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REP_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REP_RATE - 1);

  logic [REP_W-1:0] rep_timer_reg;
  logic             repeating_reg;
`endif

  logic               sync1_reg;
  logic               sync2_reg;
  db_state_t          state_reg;
  logic [TIMER_W-1:0] timer_reg;
  logic               pulse_reg;

  // Idle level is high so a released button never looks like a press after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= raw_n;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RELEASED;
      timer_reg <= '0;
      pulse_reg <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_timer_reg <= '0;
      repeating_reg <= 1'b0;
`endif
    end else begin
      pulse_reg <= 1'b0;
      case (state_reg)
        RELEASED:
          if (!sync2_reg) begin
            state_reg <= PRESS_WAIT;
            timer_reg <= '0;
          end
        PRESS_WAIT:
          if (sync2_reg) begin
            state_reg <= RELEASED;
          end else if (timer_reg == DB_LAST) begin
            state_reg <= PRESSED;
            pulse_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        PRESSED:
          if (sync2_reg) begin
            state_reg <= RELEASE_WAIT;
            timer_reg <= '0;
          end
`ifdef AUTO_REPEAT_EN
          // First repeat waits the long delay, later ones the short rate.
          else if (rep_timer_reg == (repeating_reg ? RATE_LAST : DELAY_LAST)) begin
            pulse_reg     <= 1'b1;
            rep_timer_reg <= '0;
            repeating_reg <= 1'b1;
          end else begin
            rep_timer_reg <= rep_timer_reg + 1'b1;
          end
`endif
        RELEASE_WAIT:
          if (!sync2_reg) begin
            state_reg <= PRESSED;
          end else if (timer_reg == DB_LAST) begin
            state_reg <= RELEASED;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        default: state_reg <= RELEASED;
      endcase
`ifdef AUTO_REPEAT_EN
      if (state_reg == RELEASED || state_reg == PRESS_WAIT) begin
        rep_timer_reg <= '0;
        repeating_reg <= 1'b0;
      end
`endif
    end
  end

  assign event_pulse = pulse_reg;

endmodule

// File: rtl/button_counter.sv
// Two debounced buttons driving an 8-bit wrapping up/down event count.
// Define AUTO_REPEAT_EN to enable hold-to-repeat in both debouncers.
module button_counter
  import button_counter_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = 25_000_000,
  parameter int unsigned DEBOUNCE_MS     = 10,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up_n,
  input  logic               btn_down_n,
  output logic [COUNT_W-1:0] count,
  output logic               up_pulse,
  output logic               down_pulse
);

  logic [1:0]         raw_n;
  logic [1:0]         pulse;
  logic [COUNT_W-1:0] count_reg;

  // Index 0 is the up button, index 1 the down button.
  assign raw_n = {btn_down_n, btn_up_n};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      button_debounce #(
        .CLK_FREQ        (CLK_FREQ),
        .DEBOUNCE_MS     (DEBOUNCE_MS),
        .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
        .REPEAT_RATE_MS  (REPEAT_RATE_MS)
      ) u_debounce (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_n       (raw_n[gi]),
        .event_pulse (pulse[gi])
      );
    end
  endgenerate

  assign up_pulse   = pulse[0];
  assign down_pulse = pulse[1];

  // Simultaneous up and down events cancel; both pulses remain visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      case ({up_pulse, down_pulse})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_button_counter.sv
// Directed bench for button_counter: vector table plus multi-cycle press sequences.
// Expected repeat behaviour follows whether AUTO_REPEAT_EN is defined.
module tb_button_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up_n = 1'b1;
  logic       btn_down_n = 1'b1;
  logic [7:0] count;
  logic       up_pulse;
  logic       down_pulse;

  int errors = 0;
  int checks = 0;

  button_counter #(
    .CLK_FREQ        (1000),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (20),
    .REPEAT_RATE_MS  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_up_n   (btn_up_n),
    .btn_down_n (btn_down_n),
    .count      (count),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic up_n;
    logic dn_n;
    logic exp_up;
    logic exp_dn;
    int   exp_cnt;
    string tag;
  } vec_t;

  vec_t vecs[$];

`ifdef AUTO_REPEAT_EN
  localparam int EXP_REP = 5;
`else
  localparam int EXP_REP = 1;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void add(input logic u, input logic d, input logic eu, input logic ed,
                              input int c, input string tag);
    vec_t v;
    v.up_n = u; v.dn_n = d; v.exp_up = eu; v.exp_dn = ed; v.exp_cnt = c; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    btn_up_n = 1'b1;
    btn_down_n = 1'b1;
    repeat (3) tick();
    check("reset_count", 32'(count), 0);
    check("reset_up_pulse", 32'(up_pulse), 0);
    check("reset_down_pulse", 32'(down_pulse), 0);
    $display("reset: count=%0d up=%0d down=%0d", count, up_pulse, down_pulse);
    rst_n = 1'b1;
  endtask

  // 8 cycles low then 8 high: long enough to accept the press and re-arm after release.
  task automatic press(input bit up, output int ups, output int dns);
    ups = 0;
    dns = 0;
    for (int k = 0; k < 16; k++) begin
      btn_up_n   = up ? (k >= 8) : 1'b1;
      btn_down_n = up ? 1'b1 : (k >= 8);
      tick();
      ups += int'(up_pulse);
      dns += int'(down_pulse);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int ups, dns, tot_up, tot_dn, both_k;
    int pulse_ks[$];
    logic [3:0] bounce;

    // Bounce: low 2, high 1, low 3, then high; never stable for 4 cycles.
    bounce = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      bounce[0] = (k == 2 || k >= 6);
      add(bounce[0], 1'b1, 1'b0, 1'b0, 0, "bounce");
    end
    // Clean press held 12 cycles: pulse in the cycle after edge 6, count 1 from edge 7.
    for (int k = 0; k < 20; k++)
      add((k < 12) ? 1'b0 : 1'b1, 1'b1, (k == 6), 1'b0, (k >= 7) ? 1 : 0, "press");

    tick();
    do_reset();

    foreach (vecs[i]) begin
      btn_up_n   = vecs[i].up_n;
      btn_down_n = vecs[i].dn_n;
      tick();
      $display("vec %0d %s: up_n=%0d dn_n=%0d -> up=%0d down=%0d count=%0d",
               i, vecs[i].tag, vecs[i].up_n, vecs[i].dn_n, up_pulse, down_pulse, count);
      check({vecs[i].tag, "_up_pulse"}, 32'(up_pulse), 32'(vecs[i].exp_up));
      check({vecs[i].tag, "_down_pulse"}, 32'(down_pulse), 32'(vecs[i].exp_dn));
      check({vecs[i].tag, "_count"}, 32'(count), 32'(vecs[i].exp_cnt));
    end

    // 256 presses from zero wrap back to zero.
    do_reset();
    tot_up = 0;
    tot_dn = 0;
    for (int i = 0; i < 256; i++) begin
      press(1'b1, ups, dns);
      tot_up += ups;
      tot_dn += dns;
      $display("up press %0d: pulses=%0d count=%0d", i, ups, count);
      if (i == 254) check("count_at_255", 32'(count), 255);
    end
    check("wrap_count", 32'(count), 0);
    check("wrap_up_pulses", 32'(tot_up), 256);
    check("wrap_down_pulses", 32'(tot_dn), 0);

    press(1'b0, ups, dns);
    $display("down press: pulses=%0d count=%0d", dns, count);
    check("underflow_count", 32'(count), 255);
    check("underflow_down_pulses", 32'(dns), 1);
    check("underflow_up_pulses", 32'(ups), 0);

    // Both buttons on the same edge: pulses coincide, count unchanged.
    ups = 0;
    dns = 0;
    both_k = -1;
    for (int k = 0; k < 22; k++) begin
      btn_up_n   = (k >= 12);
      btn_down_n = (k >= 12);
      tick();
      ups += int'(up_pulse);
      dns += int'(down_pulse);
      if (up_pulse && down_pulse) both_k = k;
    end
    $display("both press: up=%0d down=%0d both_at=%0d count=%0d", ups, dns, both_k, count);
    check("both_cycle", 32'(both_k), 6);
    check("both_up_pulses", 32'(ups), 1);
    check("both_down_pulses", 32'(dns), 1);
    check("both_count", 32'(count), 255);

    // Long hold: PRESSED entered at edge 6, released before the edge-46 repeat slot.
    do_reset();
    for (int k = 0; k < 52; k++) begin
      btn_up_n = (k >= 42);
      tick();
      if (up_pulse) pulse_ks.push_back(k);
    end
    $display("long hold: pulses=%0d count=%0d", pulse_ks.size(), count);
    check("hold_pulses", 32'(pulse_ks.size()), 32'(EXP_REP));
    check("hold_first_pulse", (pulse_ks.size() > 0) ? 32'(pulse_ks[0]) : 32'hFFFF_FFFF, 6);
    check("hold_count", 32'(count), 32'(EXP_REP));
`ifdef AUTO_REPEAT_EN
    check("repeat_first", (pulse_ks.size() > 1) ? 32'(pulse_ks[1]) : 32'hFFFF_FFFF, 26);
    check("repeat_last", (pulse_ks.size() > 4) ? 32'(pulse_ks[4]) : 32'hFFFF_FFFF, 41);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_counter.md
# button_counter

Input-side companion to the LED counter: reads two raw active-low push-buttons (up, down), synchronizes and debounces each, and maintains an 8-bit wrapping count that drives the board LEDs or any downstream consumer. It sits between board pins and user logic, converting noisy mechanical presses into clean single-cycle event pulses plus a registered count.

## Interface
- CLK_FREQ, 25_000_000: clock frequency in Hz; must be ≥ 1000.
- DEBOUNCE_MS, 10: stable time required to accept a press/release; ≥ 1.
- REPEAT_DELAY_MS, 500: hold time before first auto-repeat (used only with AUTO_REPEAT_EN).
- REPEAT_RATE_MS, 100: interval between subsequent auto-repeats (used only with AUTO_REPEAT_EN).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- btn_up_n  in  1  raw up button, active-low, asynchronous to clk.
- btn_down_n  in  1  raw down button, active-low, asynchronous to clk.
- count  out  8  registered event count.
- up_pulse  out  1  one-cycle accepted up event.
- down_pulse  out  1  one-cycle accepted down event.

## Operation
- Derived constant: DB_CYCLES = (CLK_FREQ/1000)*DEBOUNCE_MS; analogous REP_DELAY, REP_RATE. Computed in 32-bit; counter widths are $clog2 of the largest value used.
- Per button: 2-FF synchronizer; reset value 1 (released).
- Per-button debounce FSM, states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT; one timer:
  - RELEASED: synced=0 → PRESS_WAIT, timer=0.
  - PRESS_WAIT: synced=1 → RELEASED; timer==DB_CYCLES-1 → PRESSED with a one-cycle event pulse; else timer+1.
  - PRESSED: synced=1 → RELEASE_WAIT, timer=0.
  - RELEASE_WAIT: synced=0 → PRESSED (no pulse); timer==DB_CYCLES-1 → RELEASED; else timer+1.
- Count update on the edge after a pulse: up only → +1, wraps 255→0; down only → −1, wraps 0→255; both in the same cycle → unchanged, with both pulses still asserted.
- Reset: count=0, up_pulse=0, down_pulse=0, FSMs RELEASED, timers 0, synchronizers 1. A button held through reset deassertion is debounced and counted as a new press.

## Timing
- Raw input low, first sampled at edge 0: sync stage 2 is low after edge 1; FSM enters PRESS_WAIT at edge 2; enters PRESSED at edge 2+DB_CYCLES; pulse is high for exactly the cycle following that edge; count changes at edge 3+DB_CYCLES.
- A glitch shorter than DB_CYCLES cycles (as seen at stage 2) produces no pulse.
- Release is not an event; it only re-arms the FSM after DB_CYCLES stable-high cycles.
- Pulses are registered outputs; no combinational path from inputs to outputs.

## Configuration
- AUTO_REPEAT_EN defined: per button, a repeat timer runs only in PRESSED, holds in RELEASE_WAIT, and clears in RELEASED/PRESS_WAIT. An extra pulse fires when PRESSED time reaches REP_DELAY cycles, then every REP_RATE cycles while the button stays held. Repeat pulses update count identically to press pulses.
- AUTO_REPEAT_EN undefined: no repeat timers are synthesized; exactly one pulse per accepted press.

## Structure
- Package button_counter_pkg: debounce state enum, ms-to-cycles constant function, and COUNT_W=8.
- Sub-module button_debounce (synchronizer + FSM + optional repeat logic, output event pulse), instantiated twice; the top level holds the count register and the simultaneous-event logic.

## Test plan
Bench parameters: CLK_FREQ=1000, DEBOUNCE_MS=4 (DB_CYCLES=4), REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5.
- Reset asserted for 3 cycles with buttons released → count=0, both pulses 0.
- btn_up_n low at edge 0 and held 12 cycles → up_pulse high only in the cycle after edge 6; count=1 from edge 7 onward; no further change after release.
- Bounce on up: low 2 cycles, high 1, low 3, high → no pulse, count stays 0.
- 256 clean up presses from count 0 → count=0 (wrap); then one down press → count=255.
- Both buttons pressed on the same edge and held 12 cycles → up_pulse and down_pulse high in the same cycle, count unchanged.
- With AUTO_REPEAT_EN: hold up for 36 cycles after entering PRESSED → pulses at entry, +20, +25, +30, +35; count=5. Without the macro, the same stimulus → count=1.
